// File: rtl/song_reader.sv
// song_reader: walks an external song ROM (registered read, one-cycle latency)
// and hands one note/duration pair at a time to the note player with a
// single-cycle load strobe. It waits for the player's done pulse before
// fetching the next entry and flags the end of the song.
//
// Optional build macro SONG_READER_LOOP_EN: instead of stopping at the end of
// the song, restart from entry 0 and pulse song_done for one cycle.
module song_reader #(
    parameter int NOTE_IDX_W = 5,
    parameter int SONG_W     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play,
    input  logic [SONG_W-1:0]            song_sel,
    input  logic                         note_done,
    output logic [SONG_W+NOTE_IDX_W-1:0] rom_addr,
    input  logic [11:0]                  rom_data,
    output logic [5:0]                   note_to_load,
    output logic [5:0]                   duration_to_load,
    output logic                         load_new_note,
    output logic                         song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        PLAY,
        END
    } state_t;

    localparam logic [NOTE_IDX_W-1:0] LAST_IDX = '1;

    state_t                  state, next_state;
    logic [NOTE_IDX_W-1:0]   note_idx;
    logic [SONG_W-1:0]       song_sel_q;

    logic song_change;
    logic idx_clr;
    logic idx_inc;
    logic capture;
    logic song_end;

    assign song_change = (song_sel != song_sel_q);
    assign rom_addr    = {song_sel_q, note_idx};

    // The strobe follows play live in LOAD, and is suppressed on a song change edge.
    assign load_new_note = (state == LOAD) && play && !song_change;

    // Next-state and datapath control decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        next_state = state;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        capture    = 1'b0;
        song_end   = 1'b0;

        if (song_change) begin
            next_state = play ? FETCH : IDLE;
            idx_clr    = 1'b1;
        end else begin
            case (state)
                IDLE:  if (play) next_state = FETCH;
                FETCH: next_state = WAIT;
                WAIT: begin
                    // Duration 0 marks the end of the song; the output registers keep the last note.
                    if (rom_data[5:0] == 6'd0) begin
                        song_end = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        next_state = LOAD;
                    end
                end
                LOAD:  if (play) next_state = PLAY;
                PLAY: begin
                    if (note_done && play) begin
                        if (note_idx == LAST_IDX) begin
                            song_end = 1'b1;
                        end else begin
                            idx_inc    = 1'b1;
                            next_state = FETCH;
                        end
                    end
                end
                END:     next_state = END;
                default: next_state = IDLE;
            endcase

            if (song_end) begin
`ifdef SONG_READER_LOOP_EN
                next_state = FETCH;
                idx_clr    = 1'b1;
`else
                next_state = END;
`endif
            end
        end
    end

    // State, note index, captured ROM word and end flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state            <= IDLE;
            note_idx         <= '0;
            song_sel_q       <= song_sel;
            note_to_load     <= 6'd0;
            duration_to_load <= 6'd0;
            song_done        <= 1'b0;
        end else begin
            state      <= next_state;
            song_sel_q <= song_sel;

            if (idx_clr) begin
                note_idx <= '0;
            end else if (idx_inc) begin
                note_idx <= note_idx + NOTE_IDX_W'(1);
            end

            if (capture) begin
                note_to_load     <= rom_data[11:6];
                duration_to_load <= rom_data[5:0];
            end

`ifdef SONG_READER_LOOP_EN
            song_done <= song_end;
`else
            if (song_change) begin
                song_done <= 1'b0;
            end else if (song_end) begin
                song_done <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: directed latency / pause / song-change / reset
// scenarios, then randomized songs played by a simple note-player model and
// checked against the expected sequence of ROM entries.
module tb_song_reader;

`ifdef SONG_READER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct packed {
        logic [6:0]  addr;
        logic [11:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song_sel;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        song_done;

    logic [11:0] rom [128];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // External ROM model: registered read, one-cycle latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    song_reader #(.NOTE_IDX_W(5), .SONG_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song_sel         (song_sel),
        .note_done        (note_done),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .song_done        (song_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ent(input int n, input int d);
        return {n[5:0], d[5:0]};
    endfunction

    // Move to 1 time unit after the next rising edge; note_done is a pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        note_done = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_load(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            settle();
            if (load_new_note) seen = 1'b1;
        end
        check({tag, "_strobe"}, 32'(seen), 32'd1);
    endtask

    task automatic check_load(input string tag, input logic [6:0] addr);
        logic [11:0] w;
        w = rom[addr];
        check({tag, "_addr"}, 32'(rom_addr), 32'(addr));
        check({tag, "_note"}, 32'(note_to_load), 32'(w[11:6]));
        check({tag, "_dur"}, 32'(duration_to_load), 32'(w[5:0]));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !song_done; i++) begin
            tick();
            settle();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t   exp_q[$];
        exp_t   e;
        int     strobes;
        logic [1:0] cur_sel;

        reset = 1'b0; play = 1'b0; note_done = 1'b0; song_sel = 2'd1;
        for (int i = 0; i < 128; i++) rom[i] = ent($urandom_range(0, 63), $urandom_range(1, 63));
        rom[7'h20] = ent(20, 12);
        for (int i = 0; i < 4; i++) rom[i] = ent(10 + i, 5 + i);
        rom[7'h04] = ent(33, 0);
        rom[7'h40] = ent(45, 7);

        // Reset values.
        tick(); settle();
        check("rst_addr", 32'(rom_addr), 32'h20);
        check("rst_load", 32'(load_new_note), 32'd0);
        check("rst_note", 32'(note_to_load), 32'd0);
        check("rst_dur", 32'(duration_to_load), 32'd0);
        check("rst_done", 32'(song_done), 32'd0);

        // First note latency from play.
        reset = 1'b1; play = 1'b1;
        tick(); settle(); check("t1_k", 32'(load_new_note), 32'd0);
        tick(); settle(); check("t1_k1", 32'(load_new_note), 32'd0);
        tick(); settle(); check("t1_k2", 32'(load_new_note), 32'd1);
        check_load("t1", 7'h20);
        tick(); settle(); check("t1_k3", 32'(load_new_note), 32'd0);

        // Song 0: four notes then the end marker.
        song_sel = 2'd0;
        tick(); settle();
        check("t2_chg_addr", 32'(rom_addr), 32'h00);
        for (int i = 0; i < 4; i++) begin
            wait_load($sformatf("t2_%0d", i), 8);
            check_load($sformatf("t2_%0d", i), 7'(i));
            check("t2_done_low", 32'(song_done), 32'd0);
            tick(); note_done = 1'b1;
        end
        wait_done(10);
        check("t2_done", 32'(song_done), 32'd1);
        if (LOOP) begin
            check("t2_loop_addr", 32'(rom_addr), 32'h00);
            tick(); settle();
            check("t2_loop_pulse", 32'(song_done), 32'd0);
            wait_load("t2_loop", 8);
            check_load("t2_loop", 7'h00);
        end else begin
            check("t2_keep_note", 32'(note_to_load), 32'(rom[3][11:6]));
            check("t2_keep_dur", 32'(duration_to_load), 32'(rom[3][5:0]));
            strobes = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (i % 5 == 0) note_done = 1'b1;
                settle();
                if (load_new_note) strobes++;
            end
            check("t2_end_strobes", 32'(strobes), 32'd0);
            check("t2_end_held", 32'(song_done), 32'd1);
        end

        // Song 3: pause in LOAD, then pause in PLAY.
        song_sel = 2'd3;
        tick(); settle();
        check("t3_addr", 32'(rom_addr), 32'h60);
        check("t3_done_clr", 32'(song_done), 32'd0);
        tick();
        tick(); play = 1'b0; settle();
        check("t3_pause0", 32'(load_new_note), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) note_done = 1'b1;
            settle();
            check("t3_pause", 32'(load_new_note), 32'd0);
        end
        check("t3_pause_addr", 32'(rom_addr), 32'h60);
        tick(); play = 1'b1; settle();
        check("t3_resume", 32'(load_new_note), 32'd1);
        check_load("t3_resume", 7'h60);
        tick(); settle();
        check("t3_one_cycle", 32'(load_new_note), 32'd0);
        play = 1'b0; note_done = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("t3_play_pause", 32'(load_new_note), 32'd0);
        end
        check("t3_idx_held", 32'(rom_addr), 32'h60);
        play = 1'b1;
        tick(); note_done = 1'b1;
        tick(); settle(); check("t3_n2n_k", 32'(load_new_note), 32'd0);
        tick(); settle(); check("t3_n2n_k1", 32'(load_new_note), 32'd0);
        tick(); settle(); check("t3_n2n_k2", 32'(load_new_note), 32'd1);
        check_load("t3_n2n", 7'h61);

        // Song change 3->2 together with note_done.
        tick(); song_sel = 2'd2; note_done = 1'b1;
        tick(); settle();
        check("t4_addr", 32'(rom_addr), 32'h40);
        check("t4_done", 32'(song_done), 32'd0);
        check("t4_load", 32'(load_new_note), 32'd0);
        tick();
        tick(); settle();
        check("t4_strobe", 32'(load_new_note), 32'd1);
        check_load("t4", 7'h40);

        // Song change in a LOAD cycle suppresses the strobe; then all 32 entries of song 1.
        tick(); note_done = 1'b1;
        tick(); tick(); tick();
        song_sel = 2'd1; settle();
        check("t5_chg_in_load", 32'(load_new_note), 32'd0);
        for (int i = 0; i < 32; i++) begin
            wait_load($sformatf("t5_%0d", i), 8);
            check_load($sformatf("t5_%0d", i), 7'(32 + i));
            check("t5_done_low", 32'(song_done), 32'd0);
            tick(); note_done = 1'b1;
        end
        wait_done(10);
        check("t5_done", 32'(song_done), 32'd1);
        if (LOOP) begin
            check("t5_loop_addr", 32'(rom_addr), 32'h20);
            tick(); settle();
            check("t5_loop_pulse", 32'(song_done), 32'd0);
            wait_load("t5_loop", 8);
            check_load("t5_loop", 7'h20);
        end else begin
            check("t5_no_wrap", 32'(rom_addr), 32'h3f);
        end

        // Reset during a strobe.
        song_sel = 2'd0;
        wait_load("t6", 8);
        reset = 1'b0; play = 1'b0;
        tick(); settle();
        check("t6_load", 32'(load_new_note), 32'd0);
        check("t6_note", 32'(note_to_load), 32'd0);
        check("t6_dur", 32'(duration_to_load), 32'd0);
        check("t6_done", 32'(song_done), 32'd0);
        check("t6_addr", 32'(rom_addr), 32'h00);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            check("t6_idle", 32'(load_new_note), 32'd0);
        end
        play = 1'b1;
        tick(); settle(); check("t6_k", 32'(load_new_note), 32'd0);
        tick(); settle(); check("t6_k1", 32'(load_new_note), 32'd0);
        tick(); settle(); check("t6_k2", 32'(load_new_note), 32'd1);
        check_load("t6", 7'h00);

        // Randomized songs against a note-player model.
        cur_sel = 2'd0;
        for (int ep = 0; ep < 8; ep++) begin
            logic [1:0] s;
            int  m, cnt, done_cnt, tail;
            bit  active, timed_out;
            s = 2'(cur_sel + 2'($urandom_range(1, 3)));
            m = $urandom_range(1, 32);
            exp_q.delete();
            for (int i = 0; i < 32; i++) begin
                rom[{s, 5'(i)}] = ent($urandom_range(0, 63), (i == m) ? 0 : $urandom_range(1, 63));
            end
            for (int pass = 0; pass < (LOOP ? 2 : 1); pass++) begin
                for (int i = 0; i < m && i < 32; i++) begin
                    e.addr = {s, 5'(i)};
                    e.word = rom[{s, 5'(i)}];
                    exp_q.push_back(e);
                end
            end
            song_sel = s; play = 1'b1; cur_sel = s;
            active = 1'b0; cnt = 0; done_cnt = 0; tail = 0; timed_out = 1'b1;
            for (int c = 0; c < 4000; c++) begin
                tick();
                play = ($urandom_range(0, 9) != 0);
                if (active) begin
                    if (cnt == 0 && play) begin
                        note_done = 1'b1;
                        active = 1'b0;
                    end else if (cnt > 0) begin
                        cnt--;
                    end
                end
                settle();
                if (song_done) done_cnt++;
                if (load_new_note) begin
                    if (exp_q.size() == 0) begin
                        check("rand_extra_strobe", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rand_addr", 32'(rom_addr), 32'(e.addr));
                        check("rand_note", 32'(note_to_load), 32'(e.word[11:6]));
                        check("rand_dur", 32'(duration_to_load), 32'(e.word[5:0]));
                        if (!LOOP) check("rand_done_early", 32'(song_done), 32'd0);
                        if (exp_q.size() > 0 || !LOOP) begin
                            active = 1'b1;
                            cnt = $urandom_range(0, 3);
                        end
                    end
                end
                if (exp_q.size() == 0 && !active) begin
                    tail++;
                    if (tail == 16) begin
                        timed_out = 1'b0;
                        break;
                    end
                end
            end
            check("rand_timeout", 32'(timed_out), 32'd0);
            check("rand_left", 32'(exp_q.size()), 32'd0);
            if (LOOP) check("rand_loop_pulses", 32'(done_cnt), 32'd1);
            else      check("rand_song_done", 32'(song_done), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Sequencer directly upstream of the note player. It walks a song ROM and presents one note/duration pair at a time, issuing a single-cycle load strobe.
- It waits for the note player's done-with-note pulse before fetching the next entry.
- It flags the end of the song to the top-level control FSM.
- The song ROM is external to this block: registered read, one-cycle latency.

Parameters:
- NOTE_IDX_W, 5, width of the per-song note index; the song holds 2^NOTE_IDX_W entries (default 32).
- SONG_W, 2, width of the song select; 2^SONG_W songs (default 4).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; reset==0 resets the block.
- play  input  1  high = advance through the song; low = pause.
- song_sel  input  SONG_W  selected song.
- note_done  input  1  one-cycle pulse from the note player's done_with_note.
- rom_addr  output  SONG_W+NOTE_IDX_W  equals {song_sel_q, note_idx}, driven from registers.
- rom_data  input  12  ROM word: [11:6] note, [5:0] duration. Valid one cycle after rom_addr changes.
- note_to_load  output  6  registered note for the note player.
- duration_to_load  output  6  registered duration for the note player.
- load_new_note  output  1  one-cycle strobe; note_to_load and duration_to_load are valid while it is high.
- song_done  output  1  level; high once the song has ended.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, note_idx=0, song_sel_q=song_sel.
  - note_to_load=0, duration_to_load=0, load_new_note=0, song_done=0.
  - rom_addr={song_sel,0} after the edge.
- States: IDLE, FETCH, WAIT, LOAD, PLAY, END.
  - IDLE: play==1 -> FETCH.
  - FETCH: one cycle to let rom_addr settle -> WAIT.
  - WAIT: capture rom_data into note_to_load/duration_to_load.
    - Duration field == 0 is the end marker -> END; the captured registers are left unchanged.
    - Otherwise -> LOAD.
  - LOAD: load_new_note = play.
    - If play==1, exit to PLAY after this cycle.
    - If play==0, hold in LOAD with load_new_note low.
  - PLAY: note_done & play.
    - If note_idx == 2^NOTE_IDX_W-1 -> END.
    - Else note_idx+1 -> FETCH.
    - note_done while play==0 is ignored.
  - END: song_done=1. The state is held until a song change or reset; note_done and play are ignored.
- Latency: play first sampled high in IDLE at edge k -> load_new_note high for exactly the cycle following edge k+2.
  - Note-to-note: note_done sampled at edge k -> next load_new_note in the cycle following edge k+2.
- Song change: song_sel != song_sel_q at an edge, in any state.
  - song_sel_q<=song_sel, note_idx<=0, song_done<=0.
  - state <= FETCH if play, else IDLE.
  - load_new_note is low that cycle.
  - Song change has priority over a simultaneous note_done.
- note_idx arithmetic is unsigned, NOTE_IDX_W bits, and never wraps silently (see Optional Feature).
- load_new_note is never high for two consecutive cycles.
- note_to_load and duration_to_load change only in WAIT.
- Reset mid-operation: a reset during any state returns to the reset values on that edge, and load_new_note drops immediately.

Optional Feature:
- Macro SONG_READER_LOOP_EN.
- Defined:
  - Reaching the last index, or the end marker, in PLAY/WAIT sets note_idx<=0 and goes to FETCH instead of END.
  - song_done pulses high for exactly one cycle at that transition.
  - END is unreachable.
- Undefined: behaviour as above; song_done is a held level.

Test Plan:
- Reset then play=1, song_sel=1, ROM[{1,0}]={note 6'd20, dur 6'd12} -> rom_addr=7'h20 and load_new_note high in the cycle after the second edge following play's first sampled-high edge, with note_to_load=20, duration_to_load=12.
- Four entries, then ROM[{0,4}] dur=0, with note_done pulsed after each load -> four load strobes at idx 0..3, then song_done=1 held; further note_done pulses produce no strobe.
- play dropped to 0 while in LOAD for 10 cycles -> no strobe during the pause; strobe in the first cycle play returns to 1. note_done pulsed while paused -> note_idx unchanged.
- song_sel 0->2 with note_done in the same cycle, play=1 -> note_idx=0, rom_addr=7'h40, song_done=0, next strobe carries ROM[{2,0}].
- All 32 entries non-zero, 32 note_done pulses -> song_done rises after the 32nd.
  - With SONG_READER_LOOP_EN: song_done is a one-cycle pulse and rom_addr returns to {sel,0}, followed by a strobe.
- reset asserted (0) in the cycle load_new_note is high -> load_new_note=0, note_to_load=0, state IDLE on the next edge; no strobe until play is sampled again.
